// File: rtl/lcd_line_writer_if.sv
// Control and panel signals between the frame controller, the clock divider and the line writer.
`timescale 1ns/1ps
interface lcd_line_writer_if #(
  parameter int LINE_PIXELS = 144
);
  logic                   clk_div;
  logic                   start;
  logic [7:0]             line_addr;
  logic [LINE_PIXELS-1:0] line_data;
  logic                   vcom;
  logic                   ready;
  logic                   done;
  logic                   lcd_scs;
  logic                   lcd_sclk;
  logic                   lcd_si;

  modport master (
    output clk_div, start, line_addr, line_data, vcom,
    input  ready, done, lcd_scs, lcd_sclk, lcd_si
  );

  modport slave (
    input  clk_div, start, line_addr, line_data, vcom,
    output ready, done, lcd_scs, lcd_sclk, lcd_si
  );
endinterface

// File: rtl/lcd_line_writer.sv
// Serialises one LS013B7DH01 gate-line write (mode, address, pixels, trailer) onto SCS/SCLK/SI,
// paced by ticks derived from the sampled clk_div.
`timescale 1ns/1ps
module lcd_line_writer #(
  parameter int LINE_PIXELS = 144,
  parameter int SETUP_TICKS = 6,
  parameter int HOLD_TICKS  = 2,
  parameter int GAP_TICKS   = 2
) (
  input  logic             Clk_12MHz,
  input  logic             Reset,
  lcd_line_writer_if.slave bus
);
  localparam int NBITS = 16 + LINE_PIXELS + 16;
  localparam int TMAX1 = (SETUP_TICKS > HOLD_TICKS) ? SETUP_TICKS : HOLD_TICKS;
  localparam int TMAX  = (TMAX1 > GAP_TICKS) ? TMAX1 : GAP_TICKS;
  localparam int CNT_W = $clog2(TMAX + 1);
  localparam logic [7:0] LAST_B = 8'(NBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_div_p0, r_div_p1, r_div_p2;
  logic                   w_tick;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [7:0]             r_b, w_b_nxt;
  logic                   r_phase, w_phase_nxt;
  logic                   r_ready, w_ready_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_scs, w_scs_nxt;
  logic                   r_sclk, w_sclk_nxt;
  logic                   r_si, w_si_nxt;
  logic                   w_accept;
  logic [7:0]             r_addr;
  logic                   r_vcom;
  logic [LINE_PIXELS-1:0] r_data;
  logic [NBITS-1:0]       w_stream;

  function automatic logic cnt_at(input logic [CNT_W-1:0] c, input int n);
    return c == CNT_W'(n);
  endfunction

  // p0/p1: two-flop synchroniser; p2: previous value for rising-edge detect
  always_ff @(posedge Clk_12MHz or posedge Reset) begin
    if (Reset) begin
      r_div_p0 <= 1'b0;
      r_div_p1 <= 1'b0;
      r_div_p2 <= 1'b0;
    end else begin
      r_div_p0 <= bus.clk_div;
      r_div_p1 <= r_div_p0;
      r_div_p2 <= r_div_p1;
    end
  end

  assign w_tick   = r_div_p1 & ~r_div_p2;
  assign w_accept = (r_state == S_IDLE) && r_ready && bus.start;

  // Line payload is captured once at accept and is data only, so it carries no reset
  always_ff @(posedge Clk_12MHz) begin
    if (w_accept) begin
      r_addr <= bus.line_addr;
      r_vcom <= bus.vcom;
      r_data <= bus.line_data;
    end
  end

  // Bit b of the transfer lives at w_stream[b]: M0=1, M1=vcom, 6 zeros, addr LSB first, pixels, 16 zeros
  assign w_stream = {16'b0, r_data, r_addr, 6'b0, r_vcom, 1'b1};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_b_nxt     = r_b;
    w_phase_nxt = r_phase;
    w_ready_nxt = r_ready;
    w_done_nxt  = 1'b0;
    w_scs_nxt   = r_scs;
    w_sclk_nxt  = r_sclk;
    w_si_nxt    = r_si;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_ready_nxt = 1'b0;
          w_scs_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_tick) begin
          if (cnt_at(r_cnt, SETUP_TICKS - 1)) begin
            w_cnt_nxt   = '0;
            w_b_nxt     = '0;
            w_phase_nxt = 1'b0;
            w_state_nxt = S_SHIFT;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_SHIFT: begin
        // SI only moves on the low phase so it is stable a full tick before each rise
        if (w_tick) begin
          if (!r_phase) begin
            w_sclk_nxt  = 1'b0;
            w_si_nxt    = w_stream[r_b];
            w_phase_nxt = 1'b1;
          end else begin
            w_sclk_nxt  = 1'b1;
            w_phase_nxt = 1'b0;
            if (r_b == LAST_B) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_HOLD;
            end else begin
              w_b_nxt = r_b + 8'd1;
            end
          end
        end
      end
      S_HOLD: begin
        if (w_tick) begin
          if (cnt_at(r_cnt, 0)) begin
            w_sclk_nxt = 1'b0;
            w_si_nxt   = 1'b0;
          end
          if (cnt_at(r_cnt, HOLD_TICKS)) begin
            w_scs_nxt   = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_GAP;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (w_tick) begin
          if (cnt_at(r_cnt, GAP_TICKS - 1)) begin
            w_done_nxt  = 1'b1;
            w_ready_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_12MHz or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_b     <= '0;
      r_phase <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_scs   <= 1'b0;
      r_sclk  <= 1'b0;
      r_si    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_b     <= w_b_nxt;
      r_phase <= w_phase_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
      r_scs   <= w_scs_nxt;
      r_sclk  <= w_sclk_nxt;
      r_si    <= w_si_nxt;
    end
  end

  assign bus.ready    = r_ready;
  assign bus.done     = r_done;
  assign bus.lcd_scs  = r_scs;
  assign bus.lcd_sclk = r_sclk;
  assign bus.lcd_si   = r_si;
endmodule

// File: tb/tb_lcd_line_writer.sv
// Bench for lcd_line_writer: directed and random lines compared against a bit-stream model.
`timescale 1ns/1ps
module tb_lcd_line_writer;
  localparam int NB = 176;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_line_writer_if bus ();
  lcd_line_writer dut (.Clk_12MHz(clk), .Reset(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // clk_div source: toggles every div_half cycles, or held high while frozen
  int div_half   = 6;
  bit div_freeze = 1'b0;
  int div_cnt    = 0;
  initial bus.clk_div = 1'b0;
  always @(negedge clk) begin
    if (div_freeze) begin
      bus.clk_div = 1'b1;
    end else begin
      div_cnt++;
      if (div_cnt >= div_half) begin
        div_cnt = 0;
        bus.clk_div = ~bus.clk_div;
      end
    end
  end

  // Panel-side monitor, all timing expressed in clk_div rising edges
  int ticks = 0, scs_rise_t = 0, scs_fall_t = 0, last_fall_t = 0, done_t = 0;
  int setup_meas = 0, hold_meas = 0, gap_meas = 0;
  int cap_n = 0, line_n = 0, si_viol = 0, scs_rises = 0, done_cnt = 0;
  bit first_rise = 1'b0;
  logic [NB-1:0] cap = '0, line_cap = '0;
  logic p_div = 1'b0, p_scs = 1'b0, p_sclk = 1'b0, p_si = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (bus.clk_div && !p_div) ticks++;
    if (bus.lcd_scs && !p_scs) begin
      gap_meas   = ticks - scs_fall_t;
      scs_rise_t = ticks;
      cap_n      = 0;
      cap        = '0;
      first_rise = 1'b1;
      scs_rises++;
    end
    if (bus.lcd_sclk && !p_sclk) begin
      if (cap_n < NB) cap[cap_n] = bus.lcd_si;
      cap_n++;
      if (first_rise) begin
        setup_meas = ticks - scs_rise_t;
        first_rise = 1'b0;
      end
    end
    if (!bus.lcd_sclk && p_sclk) last_fall_t = ticks;
    if (!bus.lcd_scs && p_scs) begin
      hold_meas  = ticks - last_fall_t;
      line_cap   = cap;
      line_n     = cap_n;
      scs_fall_t = ticks;
    end
    if ((bus.lcd_si !== p_si) && bus.lcd_sclk) si_viol++;
    if (bus.done) begin
      done_cnt++;
      done_t = ticks;
    end
    p_div  = bus.clk_div;
    p_scs  = bus.lcd_scs;
    p_sclk = bus.lcd_sclk;
    p_si   = bus.lcd_si;
  end

  // Reference: the transfer as the panel should see it, bit b at index b
  function automatic logic [NB-1:0] model(input logic [7:0] a, input logic v, input logic [143:0] d);
    logic [NB-1:0] s;
    s    = '0;
    s[0] = 1'b1;
    s[1] = v;
    for (int i = 0; i < 8; i++) s[8 + i] = a[i];
    for (int i = 0; i < 144; i++) s[16 + i] = d[i];
    return s;
  endfunction

  function automatic logic [143:0] rand_data();
    logic [159:0] t;
    for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom;
    return t[143:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_line(input string tag, input logic [7:0] a, input logic v, input logic [143:0] d);
    int t;
    t = 0;
    while (!bus.ready && t < 20000) begin
      cyc(1);
      t++;
    end
    check({tag, " ready before start"}, 64'(bus.ready), 64'd1);
    bus.line_addr = a;
    bus.vcom      = v;
    bus.line_data = d;
    bus.start     = 1'b1;
    cyc(1);
    bus.start     = 1'b0;
    bus.line_addr = 8'($urandom);
    bus.vcom      = ~v;
    bus.line_data = rand_data();
    check({tag, " scs after accept"}, 64'(bus.lcd_scs), 64'd1);
    check({tag, " ready busy"}, 64'(bus.ready), 64'd0);
  endtask

  task automatic wait_done(input string tag, input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 20000) begin
      cyc(1);
      t++;
    end
    check({tag, " done arrived"}, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic finish_line(input string tag, input logic [NB-1:0] exp, input int d0);
    wait_done(tag, d0);
    check_vec({tag, " stream"}, line_cap, exp);
    check({tag, " sclk rises"}, 64'(line_n), 64'(NB));
    check({tag, " latency in range"}, 64'((done_t - scs_rise_t) >= 362 && (done_t - scs_rise_t) <= 363), 64'd1);
    check({tag, " setup >= 7"}, 64'(setup_meas >= 7), 64'd1);
    check({tag, " hold ticks"}, 64'(hold_meas), 64'd2);
    check({tag, " si stable while sclk high"}, 64'(si_viol), 64'd0);
    cyc(1);
    check({tag, " done one cycle"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    a;
    logic          v;
    logic [143:0]  d;
    logic [143:0]  d2;
    logic [NB-1:0] e;
    logic [NB-1:0] e2;
    int            d0;
    int            base;
    int            changes;
    int            t;
    logic [4:0]    snap;
    int            cap_snap;

    bus.start     = 1'b0;
    bus.line_addr = '0;
    bus.vcom      = 1'b0;
    bus.line_data = '0;
    cyc(3);
    check("reset ready", 64'(bus.ready), 64'd1);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset scs", 64'(bus.lcd_scs), 64'd0);
    check("reset sclk", 64'(bus.lcd_sclk), 64'd0);
    check("reset si", 64'(bus.lcd_si), 64'd0);
    rst = 1'b0;
    cyc(3);

    // Divide-by-12 line: addr 1, vcom 0, all pixels set
    div_half = 6;
    d = '1;
    e = model(8'h01, 1'b0, d);
    d0 = done_cnt;
    start_line("allones", 8'h01, 1'b0, d);
    finish_line("allones", e, d0);

    // Last gate line with VCOM high and only pixel 1 set
    d = 144'd1;
    e = model(8'hA8, 1'b1, d);
    d0 = done_cnt;
    start_line("addr168", 8'hA8, 1'b1, d);
    finish_line("addr168", e, d0);

    div_half = 2;
    for (int k = 0; k < 3; k++) begin
      a = 8'($urandom_range(1, 168));
      v = 1'($urandom);
      d = rand_data();
      e = model(a, v, d);
      d0 = done_cnt;
      start_line("random", a, v, d);
      finish_line("random", e, d0);
    end

    // Two lines with start held high: second accept lands in the done cycle
    a  = 8'($urandom_range(1, 168));
    v  = 1'($urandom);
    d  = rand_data();
    e  = model(a, v, d);
    d2 = rand_data();
    e2 = model(8'd77, ~v, d2);
    base = scs_rises;
    d0 = done_cnt;
    bus.line_addr = a;
    bus.vcom      = v;
    bus.line_data = d;
    bus.start     = 1'b1;
    cyc(1);
    bus.line_addr = 8'd77;
    bus.vcom      = ~v;
    bus.line_data = d2;
    wait_done("b2b first", d0);
    check_vec("b2b first stream", line_cap, e);
    check("b2b ready in done cycle", 64'(bus.ready), 64'd1);
    check("b2b start ignored while busy", 64'(scs_rises - base), 64'd1);
    cyc(1);
    check("b2b second accept scs", 64'(bus.lcd_scs), 64'd1);
    bus.start = 1'b0;
    check("b2b gap ticks", 64'(gap_meas), 64'd2);
    d0 = done_cnt;
    finish_line("b2b second", e2, d0);
    check("b2b two lines", 64'(scs_rises - base), 64'd2);

    // clk_div frozen high mid-shift: everything holds, then resumes cleanly
    a = 8'($urandom_range(1, 168));
    v = 1'($urandom);
    d = rand_data();
    e = model(a, v, d);
    d0 = done_cnt;
    start_line("freeze", a, v, d);
    t = 0;
    while (cap_n < 60 && t < 20000) begin
      cyc(1);
      t++;
    end
    div_freeze = 1'b1;
    cyc(5);
    snap     = {bus.lcd_scs, bus.lcd_sclk, bus.lcd_si, bus.ready, bus.done};
    cap_snap = cap_n;
    changes  = 0;
    repeat (1000) begin
      cyc(1);
      if ({bus.lcd_scs, bus.lcd_sclk, bus.lcd_si, bus.ready, bus.done} !== snap) changes++;
    end
    check("freeze outputs constant", 64'(changes), 64'd0);
    check("freeze no sclk rises", 64'(cap_n), 64'(cap_snap));
    div_freeze = 1'b0;
    finish_line("freeze", e, d0);

    // Reset in the middle of the shift (bit 40)
    d0 = done_cnt;
    start_line("abort", 8'd5, 1'b1, rand_data());
    t = 0;
    while (cap_n < 40 && t < 20000) begin
      cyc(1);
      t++;
    end
    check("abort reached bit 40", 64'(cap_n), 64'd40);
    rst = 1'b1;
    #1;
    check("abort scs", 64'(bus.lcd_scs), 64'd0);
    check("abort sclk", 64'(bus.lcd_sclk), 64'd0);
    check("abort si", 64'(bus.lcd_si), 64'd0);
    check("abort ready", 64'(bus.ready), 64'd1);
    cyc(2);
    rst = 1'b0;
    cyc(400);
    check("abort no done", 64'(done_cnt - d0), 64'd0);
    check("abort idle", 64'(bus.ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
